// File: rtl/hdmi_text_pkg.sv
// Shared constants and types for the HDMI text controller register front end.
package hdmi_text_pkg;

  localparam int unsigned C_AXI_DATA_WIDTH = 32;
  localparam int unsigned C_AXI_ADDR_WIDTH = 16;
  localparam int unsigned STRB_W           = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned NUM_REGS         = 601;
  localparam int unsigned CTRL_IDX         = 600;
  localparam int unsigned VRAM_WORDS       = 600;
  localparam int unsigned IDX_W            = C_AXI_ADDR_WIDTH - 2;
  localparam int unsigned VID_ADDR_W       = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IDX_W-1:0] word_idx_t;

  // One joined write: word index, data and byte enables
  typedef struct packed {
    word_idx_t                   idx;
    logic [C_AXI_DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]           strb;
  } wr_cmd_t;

  function automatic logic in_range(input word_idx_t idx);
    return idx < IDX_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/axi_lite_vram_slave_if.sv
// AXI4-Lite signal bundle between the bus master and the VRAM register slave.
interface axi_lite_vram_slave_if;
  import hdmi_text_pkg::*;

  logic [C_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [C_AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]           wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [C_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_wr_capture.sv
// AW/W holding registers and join logic: emits one commit pulse per write and
// owns the B channel response.
module axi_lite_wr_capture
  import hdmi_text_pkg::*;
(
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [C_AXI_DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]           wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic                        bready,
  output logic                        bvalid,
  output logic [1:0]                  bresp,
  output logic                        commit_c,
  output wr_cmd_t                     cmd_c
);

  logic                        aw_held;
  logic                        w_held;
  word_idx_t                   idx_q;
  logic [C_AXI_DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]           strb_q;

  logic       aw_hs;
  logic       w_hs;
  logic       aw_held_n;
  logic       w_held_n;
  logic       bvalid_n;
  logic [1:0] bresp_n;
  logic [1:0] unused_addr_lsb;

  assign unused_addr_lsb = awaddr[1:0];

  // A channel arriving this cycle joins directly with one already held
  always_comb begin
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    cmd_c.idx  = aw_held ? idx_q  : awaddr[C_AXI_ADDR_WIDTH-1:2];
    cmd_c.data = w_held  ? data_q : wdata;
    cmd_c.strb = w_held  ? strb_q : wstrb;
    commit_c  = (aw_held || aw_hs) && (w_held || w_hs);
    aw_held_n = (aw_held || aw_hs) && !commit_c;
    w_held_n  = (w_held || w_hs) && !commit_c;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    if (bvalid && bready) begin
      bvalid_n = 1'b0;
    end
    if (commit_c) begin
      bvalid_n = 1'b1;
      bresp_n  = in_range(cmd_c.idx) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      awready <= 1'b0;
      wready  <= 1'b0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      if (aw_hs) begin
        idx_q <= awaddr[C_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      awready <= !aw_held_n && !bvalid_n;
      wready  <= !w_held_n && !bvalid_n;
    end
  end

endmodule

// File: rtl/axi_lite_vram_slave.sv
// AXI4-Lite slave holding 600 VRAM words plus a control word, with a registered
// read port and control-word tap for the text renderer.
module axi_lite_vram_slave
  import hdmi_text_pkg::*;
(
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  axi_lite_vram_slave_if.slave        s_axi,
  input  logic [VID_ADDR_W-1:0]       vid_addr,
  output logic [C_AXI_DATA_WIDTH-1:0] vid_rdata,
  output logic [C_AXI_DATA_WIDTH-1:0] ctrl_reg
);

  logic [C_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic      wr_commit_c;
  wr_cmd_t   wr_cmd_c;
  logic      ar_hs;
  logic      rvalid_n;
  word_idx_t rd_idx;
  logic      unused_bits;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0]};

  axi_lite_wr_capture u_wr_capture (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .awaddr      (s_axi.awaddr),
    .awvalid     (s_axi.awvalid),
    .awready     (s_axi.awready),
    .wdata       (s_axi.wdata),
    .wstrb       (s_axi.wstrb),
    .wvalid      (s_axi.wvalid),
    .wready      (s_axi.wready),
    .bready      (s_axi.bready),
    .bvalid      (s_axi.bvalid),
    .bresp       (s_axi.bresp),
    .commit_c    (wr_commit_c),
    .cmd_c       (wr_cmd_c)
  );

  // Register file; out-of-range commits are dropped
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit_c && in_range(wr_cmd_c.idx)) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_cmd_c.strb[b]) begin
          regs[wr_cmd_c.idx[VID_ADDR_W-1:0]][8*b +: 8] <= wr_cmd_c.data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_idx   = s_axi.araddr[C_AXI_ADDR_WIDTH-1:2];
    ar_hs    = s_axi.arvalid && s_axi.arready;
    rvalid_n = s_axi.rvalid;
    if (s_axi.rvalid && s_axi.rready) begin
      rvalid_n = 1'b0;
    end
    if (ar_hs) begin
      rvalid_n = 1'b1;
    end
  end

  // Read channel; a same-cycle commit is not yet visible to this read
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.arready <= 1'b0;
    end else begin
      s_axi.rvalid  <= rvalid_n;
      s_axi.arready <= !rvalid_n;
      if (ar_hs) begin
        if (in_range(rd_idx)) begin
          s_axi.rdata <= regs[rd_idx[VID_ADDR_W-1:0]];
          s_axi.rresp <= RESP_OKAY;
        end else begin
          s_axi.rdata <= '0;
          s_axi.rresp <= RESP_SLVERR;
        end
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      vid_rdata <= '0;
    end else if (vid_addr < VID_ADDR_W'(NUM_REGS)) begin
      vid_rdata <= regs[vid_addr];
    end else begin
      vid_rdata <= '0;
    end
  end

  assign ctrl_reg = regs[CTRL_IDX];

endmodule

// File: doc/axi_lite_vram_slave.md
# axi_lite_vram_slave

AXI4-Lite slave front end of the HDMI text controller, sitting between the bus master (MicroBlaze, or the bench transactor) and the text renderer. It decodes byte addresses into 601 32-bit registers: 600 VRAM words at indices 0–599 and a control register at index 600. It applies byte strobes on writes and returns read data with AXI handshakes. It also exposes a registered read port and the control word to the video side.

## Interface
- C_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 16, byte-address width.
- NUM_REGS, 601, number of words; the last index is the control register.
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- axi_awaddr/axi_awprot/axi_awvalid  in  16/3/1  write address channel; awprot is ignored.
- axi_awready  out  1.
- axi_wdata/axi_wstrb/axi_wvalid  in  32/4/1  write data channel.
- axi_wready  out  1.
- axi_bresp/axi_bvalid  out  2/1; axi_bready  in  1  write response channel.
- axi_araddr/axi_arprot/axi_arvalid  in  16/3/1; axi_arready  out  1  read address channel.
- axi_rdata/axi_rresp/axi_rvalid  out  32/2/1; axi_rready  in  1  read data channel.
- vid_addr  in  10  word index requested by the renderer.
- vid_rdata  out  32  word at vid_addr, registered.
- ctrl_reg  out  32  continuous copy of register 600.

## Operation
- Word index = addr[C_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored. An index ≥ NUM_REGS is out of range.
- AW and W are accepted independently, in either order or together.
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - A handshake latches the address or the data+strobe into the holding register.
- Commit happens in the cycle after both holding registers are full.
  - In range: for each byte b with wstrb[b]=1, reg[idx][8b+7:8b] ← wdata[8b+7:8b]. All other bytes are unchanged.
  - Out of range: the data is discarded.
  - bvalid is set. bresp = 2'b00 (OKAY) for in-range, 2'b10 (SLVERR) for out-of-range. Both holding registers clear.
- bvalid holds until bready. It clears on the cycle where bvalid&&bready.
- Read path:
  - arready = !rvalid.
  - On arvalid&&arready, the next cycle sets rvalid with rdata = reg[idx] and rresp = OKAY, or rdata = 0 and rresp = SLVERR for out-of-range.
  - rdata and rresp stay stable until rvalid&&rready.
- If a read is sampled in the same cycle as a write commit to the same index, it returns the pre-write value.
- vid_rdata ← reg[vid_addr] every cycle. For vid_addr ≥ NUM_REGS, vid_rdata ← 0.
- ctrl_reg is combinational from reg[600].

## Timing
- Reset (asynchronous, axi_aresetn=0) forces:
  - all 601 registers to 0;
  - the holding registers to empty;
  - awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, vid_rdata and ctrl_reg to 0.
- A reset mid-transaction abandons it; no response is issued after release.
- First cycle after release: awready = wready = arready = 1.
- Write latency: AW+W handshake at cycle N gives commit and bvalid=1 at N+1. If AW and W are split, commit happens 1 cycle after the later one.
- Back-to-back writes: at most one write per 2 cycles while bready is held high.
- Read latency: AR handshake at N gives rvalid=1 at N+1. With rready high, the next AR is accepted at N+2.
- vid_rdata latency is 1 cycle. A write committed at cycle N is visible on vid_rdata from N+2.

## Structure
- Shared package hdmi_text_pkg: NUM_REGS, CTRL_IDX=600, VRAM_WORDS=600, and AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- One natural sub-module, axi_lite_wr_capture: the AW/W holding registers and the join logic that produce a single commit pulse.
- The storage array and read logic stay in the top module.

## Test plan
- Full-word write then read: write 0xDEADBEEF to byte address 0x10 with strb=F → bresp=00. Read of 0x10 → rdata=0xDEADBEEF, rresp=00, rvalid 1 cycle after the AR handshake.
- Byte strobes: word 5 = 0x11223344. Write 0xAABBCCDD with strb=4'b0101 → readback = 0x11BB33DD. A halfword write 0x0000BEEF with strb=4'b0011 to a zeroed word → 0x0000BEEF.
- Channel ordering: present AW 3 cycles before W, then W 3 cycles before AW → both commit 1 cycle after the later handshake. awready and wready drop while the other channel is pending.
- Control and range:
  - Write 0x001F6000 to byte address 2400 → ctrl_reg = 0x001F6000.
  - Write to 2404 → bresp=10, and no register changes.
  - Read of 2404 → rdata=0, rresp=10.
- Backpressure and video port: hold bready=0 for 5 cycles → bvalid stays 1 and awready=0. Set vid_addr=7 after writing word 7 = 0x00000041 → vid_rdata=0x41 within 2 cycles of commit.
- Async reset mid-write: assert axi_aresetn low between the AW and W handshakes → all outputs 0 immediately, and a read after release returns 0.
